// File: rtl/rv32i_pkg.sv
// rv32i_pkg: types and constants shared by the RV32I fetch stage.
//   INSTR_W / XLEN    instruction and address widths
//   DEFAULT_RESET_PC  PC loaded on reset unless the top overrides it
//   fetch_state_t     fetch sequencer states
//   fetch_entry_t     one buffered instruction word with its PC
package rv32i_pkg;

   localparam int INSTR_W = 32;
   localparam int XLEN    = 32;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t feeding the decoder.
//   clk, reset    clock and synchronous active-high reset
//   push / entry  write one entry at the tail
//   pop           drop the head entry (ignored when empty)
//   flush         empty the FIFO; wins over push and pop
//   count         number of valid entries (0..DEPTH)
//   head          entry at the head of the FIFO
//   empty         no valid entries
// A push while full is only accepted together with a pop.
module fetch_fifo
   import rv32i_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  fetch_entry_t  entry,
   input  logic          pop,
   input  logic          flush,
   output logic [CW-1:0] count,
   output fetch_entry_t  head,
   output logic          empty
);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= entry;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   no_overflow_a : assert property (@(posedge clk) disable iff (reset)
      (push && !flush) |-> (!full || do_pop));

endmodule

// File: rtl/rv32i_fetch.sv
// rv32i_fetch: instruction fetch stage in front of the RV32I decoder.
//   clk, reset                  clock, synchronous active-high reset
//   imem_req_valid/ready/addr   word request channel to instruction memory
//   imem_rsp_valid/data         in-order response channel (latency >= 1)
//   redirect_valid/redirect_pc  branch/jump redirect from downstream
//   instr_valid/ready           handshake to the decoder
//   instr, instr_pc             buffered word and its PC
//   fetch_fault                 sticky misaligned-redirect flag
//
// state | meaning
// ------+-----------------------------------------------------------
// BOOT  | first cycle after reset, no requests, nothing presented
// RUN   | issue requests under credit, present buffered words
// FAULT | misaligned redirect seen, idle until an aligned redirect
module rv32i_fetch
   import rv32i_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [XLEN-1:0]    imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [XLEN-1:0]    instr_pc,
   output logic               fetch_fault
);

   localparam int CW  = $clog2(FIFO_DEPTH) + 1;
   localparam int SW  = CW + 1;

   fetch_state_t    state;
   fetch_state_t    state_nxt;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] rsp_pc;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   discard;
   logic [CW-1:0]   fifo_count;
   logic [SW-1:0]   credit_used;
   logic            credit_ok;
   logic            fifo_empty;
   logic            fifo_push;
   logic            fifo_pop;
   logic            req_fire;
   logic            redir_aligned;
   fetch_entry_t    fifo_head;
   fetch_entry_t    rsp_entry;

   // Credit counts every request still in flight (stale ones included)
   // plus buffered words, so a returning response always has a slot.
   assign credit_used   = SW'(outstanding) + SW'(fifo_count);
   assign credit_ok     = (credit_used < SW'(FIFO_DEPTH));
   assign redir_aligned = (redirect_pc[1:0] == 2'b00);
   assign req_fire      = imem_req_valid && imem_req_ready;
   assign fifo_push     = imem_rsp_valid && (discard == '0) && !redirect_valid;
   assign fifo_pop      = instr_valid && instr_ready;
   assign rsp_entry     = '{pc: rsp_pc, instr: imem_rsp_data};

   assign imem_req_addr = pc;
   assign instr         = fifo_head.instr;
   assign instr_pc      = fifo_head.pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      imem_req_valid = 1'b0;
      instr_valid    = 1'b0;
      case (state)
         BOOT: begin
            state_nxt = RUN;
         end
         RUN: begin
            imem_req_valid = credit_ok && !redirect_valid;
            instr_valid    = !fifo_empty;
         end
         FAULT: begin
            state_nxt = FAULT;
         end
         default: begin
            state_nxt = BOOT;
         end
      endcase
      if (redirect_valid) begin
         state_nxt = redir_aligned ? RUN : FAULT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         fetch_fault <= 1'b0;
      end else begin
         outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
         if (redirect_valid) begin
            // Everything still in flight is stale after a redirect, whether
            // or not it was already marked for discard; this cycle's
            // response (if any) is dropped here.
            discard <= outstanding - CW'(imem_rsp_valid);
            if (redir_aligned) begin
               pc          <= redirect_pc;
               rsp_pc      <= redirect_pc;
               fetch_fault <= 1'b0;
            end else begin
               fetch_fault <= 1'b1;
            end
         end else begin
            if (req_fire) begin
               pc <= pc + 32'd4;
            end
            if (imem_rsp_valid) begin
               if (discard != '0) begin
                  discard <= discard - CW'(1);
               end else begin
                  rsp_pc <= rsp_pc + 32'd4;
               end
            end
         end
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .entry (rsp_entry),
      .pop   (fifo_pop),
      .flush (redirect_valid),
      .count (fifo_count),
      .head  (fifo_head),
      .empty (fifo_empty)
   );

   rsp_expected_a : assert property (@(posedge clk) disable iff (reset)
      imem_rsp_valid |-> (outstanding != '0));

   req_stable_a : assert property (@(posedge clk) disable iff (reset)
      (imem_req_valid && !imem_req_ready && !redirect_valid) |=>
      (reset || redirect_valid || (imem_req_valid && $stable(imem_req_addr))));

endmodule

// File: tb/tb_rv32i_fetch.sv
module tb_rv32i_fetch;

   localparam int          DEPTH = 2;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        fetch_fault;

   always #5 clk = ~clk;

   rv32i_fetch #(
      .RESET_PC   (RPC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .fetch_fault    (fetch_fault)
   );

   int n_chk = 0;
   int n_fail = 0;

   // stimulus knobs
   int unsigned p_rdy = 100;
   int unsigned p_irdy = 100;
   int unsigned p_redir = 0;
   int unsigned lat_min = 1;
   int unsigned lat_max = 1;
   bit          rand_data = 1'b0;
   bit          rst_drv = 1'b1;
   bit          force_redir = 1'b0;
   logic [31:0] force_pc = '0;
   bit          want_coinc = 1'b0;
   bit          coinc_hit = 1'b0;

   // reference model: memory in flight, decoder-visible buffer, mode flags
   logic [31:0] mq_addr[$];
   logic [31:0] mq_data[$];
   int          mq_due[$];
   bit          mq_stale[$];
   logic [31:0] bq_pc[$];
   logic [31:0] bq_ins[$];
   bit          m_boot = 1'b1;
   bit          m_fault = 1'b0;
   logic [31:0] exp_addr = RPC;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_addr = '0;
   int          cyc = 0;
   int          last_due = 0;
   int          n_acc = 0;
   int          n_pop = 0;
   int          n_drop = 0;
   logic [31:0] last_pop_pc = '0;
   logic [31:0] last_pop_ins = '0;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] rand_target();
      logic [31:0] t;
      t = $urandom & 32'h0000_FFFC;
      case ($urandom_range(9))
         0: t = t | $urandom_range(3, 1);
         1: t = 32'hFFFF_FFF8;
         default: ;
      endcase
      return t;
   endfunction

   task automatic step();
      bit          rsp;
      bit          rstale;
      bit          redir;
      bit          e_rv;
      bit          e_iv;
      bit          acc;
      bit          popv;
      logic [31:0] raddr;
      logic [31:0] rdata;
      logic [31:0] rpc;
      int          due;
      @(negedge clk);
      reset  = rst_drv;
      rsp    = 1'b0;
      rstale = 1'b0;
      raddr  = '0;
      rdata  = '0;
      if (mq_due.size() > 0) begin
         if (mq_due[0] <= cyc) begin
            rsp    = 1'b1;
            raddr  = mq_addr[0];
            rdata  = mq_data[0];
            rstale = mq_stale[0];
         end
      end
      imem_rsp_valid = rsp;
      imem_rsp_data  = rsp ? rdata : $urandom;
      imem_req_ready = ($urandom_range(99) < p_rdy);
      instr_ready    = ($urandom_range(99) < p_irdy);
      e_iv  = !m_boot && !m_fault && (bq_pc.size() > 0);
      redir = force_redir || ($urandom_range(999) < p_redir);
      rpc   = force_redir ? force_pc : rand_target();
      if (want_coinc && rsp && e_iv && !rst_drv) begin
         redir       = 1'b1;
         rpc         = 32'h300;
         instr_ready = 1'b1;
         want_coinc  = 1'b0;
         coinc_hit   = 1'b1;
      end
      force_redir    = 1'b0;
      redirect_valid = redir;
      redirect_pc    = redir ? rpc : $urandom;
      e_rv = !m_boot && !m_fault && !redir && ((mq_addr.size() + bq_pc.size()) < DEPTH);
      #1;
      chk_val("req_valid", imem_req_valid, e_rv);
      if (e_rv) chk_val("req_addr", imem_req_addr, exp_addr);
      if (prev_stall && !redir) begin
         chk_val("stall_valid", imem_req_valid, 1'b1);
         chk_val("stall_addr", imem_req_addr, prev_addr);
      end
      chk_val("instr_valid", instr_valid, e_iv);
      if (e_iv) begin
         chk_val("instr_pc", instr_pc, bq_pc[0]);
         chk_val("instr", instr, bq_ins[0]);
      end
      chk_val("fetch_fault", fetch_fault, m_fault);
      if (m_boot) begin
         chk_val("boot_addr", imem_req_addr, RPC);
         chk_val("boot_instr", instr, 32'h0);
         chk_val("boot_pc", instr_pc, 32'h0);
      end
      if (rst_drv) begin
         mq_addr.delete();
         mq_data.delete();
         mq_due.delete();
         mq_stale.delete();
         bq_pc.delete();
         bq_ins.delete();
         m_boot     = 1'b1;
         m_fault    = 1'b0;
         exp_addr   = RPC;
         prev_stall = 1'b0;
         n_acc      = 0;
         last_due   = 0;
      end else begin
         acc  = e_rv && imem_req_ready;
         popv = e_iv && instr_ready;
         if (popv) begin
            last_pop_pc  = bq_pc.pop_front();
            last_pop_ins = bq_ins.pop_front();
            n_pop++;
         end
         if (rsp) begin
            mq_addr.delete(0);
            mq_data.delete(0);
            mq_due.delete(0);
            mq_stale.delete(0);
            if (rstale || redir) begin
               n_drop++;
            end else begin
               bq_pc.push_back(raddr);
               bq_ins.push_back(rdata);
            end
         end
         if (redir) begin
            bq_pc.delete();
            bq_ins.delete();
            foreach (mq_stale[i]) mq_stale[i] = 1'b1;
            if (rpc[1:0] == 2'b00) begin
               exp_addr = rpc;
               m_fault  = 1'b0;
            end else begin
               m_fault = 1'b1;
            end
         end
         m_boot = 1'b0;
         if (acc) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq_addr.push_back(exp_addr);
            mq_data.push_back(rand_data ? $urandom : 32'h0000_0013);
            mq_due.push_back(due);
            mq_stale.push_back(1'b0);
            exp_addr = exp_addr + 32'd4;
            n_acc++;
         end
         prev_stall = e_rv && !imem_req_ready;
         prev_addr  = exp_addr;
      end
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_until_pop(input int budget, output bit hit);
      int start;
      start = n_pop;
      for (int i = 0; i < budget && n_pop == start; i++) step();
      hit = (n_pop != start);
   endtask

   task automatic do_reset();
      rst_drv = 1'b1;
      step();
      rst_drv = 1'b0;
   endtask

   initial begin
      bit hit;
      int d0;
      int p0;
      reset = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      instr_ready    = 1'b0;
      repeat (2) @(posedge clk);
      do_reset();

      // straight-line fetch, latency 1, constant nop words
      rand_data = 1'b0;
      run(30);
      chk_val("p1_progress", (n_pop >= 8), 1'b1);
      chk_val("p1_word", last_pop_ins, 32'h0000_0013);

      // decoder stalled: only DEPTH requests go out
      rand_data = 1'b1;
      do_reset();
      p_irdy = 0;
      run(12);
      chk_val("p2_reqs", n_acc, DEPTH);
      chk_val("p2_req_valid", imem_req_valid, 1'b0);
      p_irdy = 100;
      run_until_pop(10, hit);
      chk_val("p2_first_pc", last_pop_pc, RPC);
      run(10);

      // memory not ready for three cycles
      do_reset();
      p_rdy = 0;
      run(4);
      chk_val("p3_addr", imem_req_addr, RPC);
      chk_val("p3_valid", imem_req_valid, 1'b1);
      p_rdy = 100;
      run(10);

      // redirect with two requests in flight, latency 3
      do_reset();
      lat_min = 3;
      lat_max = 3;
      for (int i = 0; i < 20 && mq_addr.size() < 2; i++) step();
      chk_val("p4_inflight", mq_addr.size(), 2);
      d0 = n_drop;
      force_redir = 1'b1;
      force_pc = 32'h100;
      run_until_pop(30, hit);
      chk_val("p4_hit", hit, 1'b1);
      chk_val("p4_first_pc", last_pop_pc, 32'h100);
      chk_val("p4_dropped", n_drop - d0, 2);

      // misaligned redirect, then recovery
      lat_min = 1;
      lat_max = 2;
      force_redir = 1'b1;
      force_pc = 32'h102;
      run(4);
      chk_val("p5_fault", fetch_fault, 1'b1);
      chk_val("p5_no_req", imem_req_valid, 1'b0);
      chk_val("p5_no_instr", instr_valid, 1'b0);
      force_redir = 1'b1;
      force_pc = 32'h200;
      run(2);
      chk_val("p5_fault_clr", fetch_fault, 1'b0);
      run_until_pop(30, hit);
      chk_val("p5_first_pc", last_pop_pc, 32'h200);

      // redirect coinciding with a response and a pop, then reset
      lat_min = 1;
      lat_max = 1;
      p_irdy = 50;
      want_coinc = 1'b1;
      p0 = n_pop;
      for (int i = 0; i < 200 && !coinc_hit; i++) begin
         p0 = n_pop;
         step();
      end
      chk_val("p6_coinc", coinc_hit, 1'b1);
      chk_val("p6_pop_once", n_pop - p0, 1);
      p_irdy = 100;
      run_until_pop(30, hit);
      chk_val("p6_redir_pc", last_pop_pc, 32'h300);
      run(5);
      rst_drv = 1'b1;
      step();
      step();
      chk_val("p6_rst_req", imem_req_valid, 1'b0);
      chk_val("p6_rst_instr", instr_valid, 1'b0);
      rst_drv = 1'b0;
      run_until_pop(30, hit);
      chk_val("p6_rst_pc", last_pop_pc, RPC);

      // address wrap, then randomized traffic with redirects
      force_redir = 1'b1;
      force_pc = 32'hFFFF_FFF8;
      run(20);
      p_rdy = 70;
      p_irdy = 60;
      p_redir = 25;
      lat_min = 1;
      lat_max = 4;
      run(3000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
